// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: sole master of the RAM block. It latches one CPU
// request per handshake and drives the RAM's level-sensitive strobes in a
// SETUP -> STROBE -> RECOVER sequence, then returns a one-cycle response.
module mem_access_sequencer #(
    parameter int unsigned adlines     = 8,
    parameter int unsigned datalines   = 16,
    parameter int unsigned ramsize     = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [adlines-1:0]   req_addr,
    input  logic [datalines-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [datalines-1:0] rsp_rdata,
    output logic [adlines-1:0]   ram_address,
    output logic [datalines-1:0] ram_datain,
    output logic                 ram_read,
    output logic                 ram_write,
    input  logic [datalines-1:0] ram_dataout
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RECOVER = 3'd3,
        RESP    = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_n;
    logic                 wr;
    logic                 wr_n;
    logic                 req_ready_n;
    logic                 rsp_valid_n;
    logic                 rsp_err_n;
    logic [datalines-1:0] rsp_rdata_n;
    logic [adlines-1:0]   ram_address_n;
    logic [datalines-1:0] ram_datain_n;
    logic                 ram_read_n;
    logic                 ram_write_n;
    logic                 addr_legal_c;

    // Range check widened so ramsize equal to 2**adlines compares correctly
    assign addr_legal_c = (32'(req_addr) < ramsize);

    // Next-state and next-output logic; every output is derived from the
    // state being entered so that all outputs come straight from flops
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        wr_n          = wr;
        rsp_rdata_n   = rsp_rdata;
        ram_address_n = ram_address;
        ram_datain_n  = ram_datain;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    wr_n = req_write;
                    if (addr_legal_c) begin
                        state_n       = SETUP;
                        ram_address_n = req_addr;
                        ram_datain_n  = req_wdata;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            SETUP: begin
                state_n = STROBE;
                cnt_n   = CNT_W'(WAIT_CYCLES - 1);
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_n = RECOVER;
                    if (!wr) begin
                        rsp_rdata_n = ram_dataout;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RECOVER: begin
                state_n = RESP;
                if (wr) begin
                    rsp_rdata_n = '0;
                end
            end
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n == ERR) begin
            rsp_rdata_n = '0;
        end

        req_ready_n = (state_n == IDLE);
        rsp_valid_n = (state_n == RESP) || (state_n == ERR);
        rsp_err_n   = (state_n == ERR);
        ram_read_n  = (state_n == STROBE) && !wr_n;
        ram_write_n = (state_n == STROBE) && wr_n;
    end

    // State, counter and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wr          <= 1'b0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            ram_address <= '0;
            ram_datain  <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            wr          <= wr_n;
            req_ready   <= req_ready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_err     <= rsp_err_n;
            rsp_rdata   <= rsp_rdata_n;
            ram_address <= ram_address_n;
            ram_datain  <= ram_datain_n;
            ram_read    <= ram_read_n;
            ram_write   <= ram_write_n;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: four instances with different ramsize /
// WAIT_CYCLES share one clock and reset, each with its own RAM model.
module tb_mem_access_sequencer;

    localparam int NI = 4;

    typedef struct packed {
        logic [1:0]  inst;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    function automatic int unsigned rs_of(input int g);
        return (g == 1) ? 200 : 256;
    endfunction

    function automatic int unsigned wc_of(input int g);
        case (g)
            2:       return 1;
            3:       return 15;
            default: return 2;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid   [NI];
    logic        req_ready   [NI];
    logic        req_write   [NI];
    logic [7:0]  req_addr    [NI];
    logic [15:0] req_wdata   [NI];
    logic        rsp_valid   [NI];
    logic        rsp_err     [NI];
    logic [15:0] rsp_rdata   [NI];
    logic [7:0]  ram_address [NI];
    logic [15:0] ram_datain  [NI];
    logic        ram_read    [NI];
    logic        ram_write   [NI];
    logic [15:0] ram_dataout [NI];

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [15:0] mem [256];

        mem_access_sequencer #(
            .adlines    (8),
            .datalines  (16),
            .ramsize    (rs_of(g)),
            .WAIT_CYCLES(wc_of(g))
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_err    (rsp_err[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .ram_address(ram_address[g]),
            .ram_datain (ram_datain[g]),
            .ram_read   (ram_read[g]),
            .ram_write  (ram_write[g]),
            .ram_dataout(ram_dataout[g])
        );

        // Level-sensitive RAM: writes on clock while write is high
        always @(posedge clk) begin
            if (ram_write[g]) mem[ram_address[g]] <= ram_datain[g];
        end
        assign ram_dataout[g] = mem[ram_address[g]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid pulse
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rsp_valid[g]) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'(g), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_inst", 32'(g), 32'(e.inst));
                    check("rsp_err", 32'(rsp_err[g]), 32'(e.err));
                    check("rsp_rdata", 32'(rsp_rdata[g]), 32'(e.rdata));
                end
            end
        end
    end

    task automatic wait_ready(input int g);
        int n = 0;
        @(negedge clk);
        while (!req_ready[g] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[g]) check("ready_timeout", 32'(g), 32'hFFFF_FFFF);
    endtask

    // One transaction with cycle-by-cycle observation relative to the accept
    task automatic run_txn(input int g, input bit wr, input logic [7:0] a,
                           input logic [15:0] d, input bit is_err, input logic [15:0] exp_rd);
        int          w;
        int          len;
        logic [31:0] stb_obs, stb_exp, rv_obs, rdy_obs;
        bit          kind_bad, addr_bad;
        exp_t        e;
        w = int'(wc_of(g));
        len = is_err ? 2 : 4 + w;
        wait_ready(g);
        req_write[g] = wr;
        req_addr[g]  = a;
        req_wdata[g] = d;
        req_valid[g] = 1'b1;
        e.inst  = 2'(g);
        e.err   = is_err;
        e.rdata = (is_err || wr) ? 16'h0 : exp_rd;
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_valid[g] = 1'b0;
        req_addr[g]  = 8'hEE;
        req_wdata[g] = 16'hDEAD;
        stb_obs = 0; rv_obs = 0; rdy_obs = 0; kind_bad = 0; addr_bad = 0;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (ram_read[g] || ram_write[g]) stb_obs[c] = 1'b1;
            if (rsp_valid[g]) rv_obs[c] = 1'b1;
            if (req_ready[g]) rdy_obs[c] = 1'b1;
            if ((wr && ram_read[g]) || (!wr && ram_write[g])) kind_bad = 1'b1;
            if (!is_err && c <= 3 + w && ram_address[g] != a) addr_bad = 1'b1;
            if (!is_err && wr && c <= 3 + w && ram_datain[g] != d) addr_bad = 1'b1;
        end
        stb_exp = is_err ? 32'h0 : ((32'h1 << w) - 32'h1) << 2;
        check("strobe_window", stb_obs, stb_exp);
        check("strobe_kind", 32'(kind_bad), 32'h0);
        check("rsp_cycle", rv_obs, 32'h1 << (len - 1));
        check("ready_cycle", rdy_obs, 32'h1 << len);
        if (!is_err) check("addr_data_held", 32'(addr_bad), 32'h0);
    endtask

    initial begin
        logic [31:0] rdy;
        exp_t        e;
        reset = 1'b1;
        for (int g = 0; g < NI; g++) begin
            req_valid[g] = 1'b0;
            req_write[g] = 1'b0;
            req_addr[g]  = 8'h0;
            req_wdata[g] = 16'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 32'({req_ready[0], rsp_valid[0], rsp_err[0], ram_read[0], ram_write[0]}), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) check("ready_after_reset", 32'(req_ready[g]), 32'h1);

        // Basic write and read-back, WAIT_CYCLES=2
        run_txn(0, 1'b1, 8'h10, 16'h000F, 1'b0, 16'h0);
        run_txn(0, 1'b0, 8'h10, 16'h0, 1'b0, 16'h000F);

        // Back-to-back with req_valid held continuously
        wait_ready(0);
        req_write[0] = 1'b1; req_addr[0] = 8'h11; req_wdata[0] = 16'h0004; req_valid[0] = 1'b1;
        e = '{inst: 2'd0, err: 1'b0, rdata: 16'h0};
        sb_q.push_back(e);
        @(posedge clk);
        #1 req_write[0] = 1'b0; req_wdata[0] = 16'h0;
        e = '{inst: 2'd0, err: 1'b0, rdata: 16'h0004};
        sb_q.push_back(e);
        rdy = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (req_ready[0]) rdy[c] = 1'b1;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        check("b2b_ready", rdy, 32'h40);
        wait_ready(0);

        // ramsize=200 boundaries
        run_txn(1, 1'b1, 8'd199, 16'h5AC7, 1'b0, 16'h0);
        run_txn(1, 1'b0, 8'd199, 16'h0, 1'b0, 16'h5AC7);
        run_txn(1, 1'b0, 8'd200, 16'h0, 1'b1, 16'h0);
        run_txn(1, 1'b1, 8'd255, 16'h1111, 1'b1, 16'h0);

        // Strobe width extremes
        run_txn(2, 1'b1, 8'h20, 16'hABCD, 1'b0, 16'h0);
        run_txn(2, 1'b0, 8'h20, 16'h0, 1'b0, 16'hABCD);
        run_txn(3, 1'b1, 8'h30, 16'h1234, 1'b0, 16'h0);
        run_txn(3, 1'b0, 8'h30, 16'h0, 1'b0, 16'h1234);

        // Reset mid-STROBE of a write: transaction discarded, no response
        wait_ready(0);
        req_write[0] = 1'b1; req_addr[0] = 8'h40; req_wdata[0] = 16'h7777; req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_strobe", 32'(ram_write[0]), 32'h1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_ctrl", 32'({req_ready[0], rsp_valid[0], rsp_err[0], ram_read[0], ram_write[0]}), 32'h0);
            check("reset_bus", 32'({rsp_rdata[0], ram_address[0]}), 32'h0);
            check("reset_datain", 32'(ram_datain[0]), 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready[0]), 32'h1);

        // Recovery after reset
        run_txn(0, 1'b0, 8'h11, 16'h0, 1'b0, 16'h0004);

        repeat (30) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
